mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 178 +++++++++++++++++
 tb/tb_mdu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit feeding the HI/LO register pair: multi-cycle
// MULT/MULTU, 32-step restoring DIV/DIVU, and single-step MTHI/MTLO moves.
module mdu_seq #(
   parameter int MUL_LAT = 2   // cycles from MULT/MULTU acceptance to the write, 2..4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        flush_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic        busy_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [2:0]  dbg_state_o
);

   // Handshake: start_i is a single-cycle request, taken only when busy_o=0 and
   // flush_i=0 (busy_o is the inverse of ready); requests while busy are dropped.
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WB} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
   logic        sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        accept;
   logic        div_neg_a, div_neg_b;
   logic [63:0] mul_a, mul_b, prod;
   logic [32:0] div_shift;
   logic        div_fit;
   logic [31:0] div_sub;

   assign accept    = (state_q == IDLE) && start_i && !flush_i &&
                      (op_i != 3'd0) && (op_i != 3'd7);
   assign div_neg_a = (op_i == OP_DIV) && op_a_i[31];
   assign div_neg_b = (op_i == OP_DIV) && op_b_i[31];

   // Low 64 bits of the product are identical for signed and unsigned once the
   // operands are sign- or zero-extended to 64 bits.
   assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
   assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = mul_a * mul_b;

   // a_q shifts the dividend out and the quotient bits in; rem_q stays below b_q.
   assign div_shift = {rem_q, a_q[31]};
   assign div_fit   = div_shift >= {1'b0, b_q};
   assign div_sub   = div_shift[31:0] - b_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      sgn_d   = sgn_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = '0;
               a_d     = op_a_i;
               b_d     = op_b_i;
               rem_d   = '0;
               sgn_d   = (op_i == OP_MULT);
               neg_a_d = 1'b0;
               neg_b_d = 1'b0;
               case (op_i)
                  OP_MULT, OP_MULTU: state_d = MUL;
                  OP_DIV, OP_DIVU: begin
                     if (op_b_i == '0) begin
                        hi_d    = op_a_i;
                        lo_d    = '1;
                        state_d = WB;
                     end else begin
                        neg_a_d = div_neg_a;
                        neg_b_d = div_neg_b;
                        a_d     = div_neg_a ? -op_a_i : op_a_i;
                        b_d     = div_neg_b ? -op_b_i : op_b_i;
                        state_d = DIV;
                     end
                  end
                  OP_MTHI: begin
                     hi_d    = op_a_i;
                     lo_d    = lo_i;
                     state_d = WB;
                  end
                  OP_MTLO: begin
                     hi_d    = hi_i;
                     lo_d    = op_a_i;
                     state_d = WB;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         MUL: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (cnt_q == 6'(MUL_LAT - 2)) begin
               {hi_d, lo_d} = prod;
               state_d      = WB;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         DIV: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               rem_d = div_fit ? div_sub : div_shift[31:0];
               a_d   = {a_q[30:0], div_fit};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = FIX;
            end
         end
         FIX: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               hi_d    = neg_a_q ? -rem_q : rem_q;
               lo_d    = (neg_a_q ^ neg_b_q) ? -a_q : a_q;
               state_d = WB;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         sgn_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         sgn_q   <= sgn_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign hilo_we_o   = (state_q == WB);
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: an arithmetic/latency model with a scoreboard checked every
// cycle, plus directed vectors with hand-computed HI/LO values.
module tb_mdu_seq;

   localparam int MUL_LAT = 2;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk, rst, start_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] op_a_i, op_b_i, hi_i, lo_i;
   logic        busy_o, hilo_we_o;
   logic [31:0] hi_o, lo_o;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   int we_cnt   = 0;
   int n_edge   = 0;
   bit m_pend   = 1'b0;
   int m_acc    = 0;
   int m_lat    = 0;
   logic [63:0] exp_q[$];

   mdu_seq #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
      .hi_i(hi_i), .lo_i(lo_i), .busy_o(busy_o), .hilo_we_o(hilo_we_o),
      .hi_o(hi_o), .lo_o(lo_o), .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Result and write latency straight from the instruction definitions.
   function automatic void model_calc(input logic [2:0] op, input logic [31:0] a, b, hin, lin,
                                      output logic [31:0] rh, rl, output int lat);
      longint sa, sb, ua, ub, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      rh = '0; rl = '0; lat = 1;
      case (op)
         OP_MULT:  begin {rh, rl} = sa * sb; lat = MUL_LAT; end
         OP_MULTU: begin {rh, rl} = ua * ub; lat = MUL_LAT; end
         OP_DIV, OP_DIVU: begin
            if (b == 32'h0) begin
               rh = a; rl = 32'hFFFF_FFFF; lat = 1;
            end else begin
               if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
               else begin q = ua / ub; r = ua % ub; end
               rl = q[31:0]; rh = r[31:0]; lat = 34;
            end
         end
         OP_MTHI: begin rh = a;   rl = lin; end
         OP_MTLO: begin rh = hin; rl = a;   end
         default: lat = 1;
      endcase
   endfunction

   // ---------------- model: acceptance, flush, completion ----------------
   initial begin
      logic [31:0] rh, rl;
      int lat;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_pend = 1'b0;
            exp_q.delete();
         end else begin
            n_edge++;
            if (m_pend && n_edge >= m_acc + m_lat) begin
               m_pend = 1'b0;
            end else if (m_pend && flush_i) begin
               m_pend = 1'b0;
               exp_q.delete();
            end else if (!m_pend && start_i && !flush_i && (op_i inside {[3'd1:3'd6]})) begin
               model_calc(op_i, op_a_i, op_b_i, hi_i, lo_i, rh, rl, lat);
               m_pend = 1'b1;
               m_acc  = n_edge;
               m_lat  = lat;
               exp_q.push_back({rh, rl});
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   initial begin
      bit exp_we;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_we = m_pend && (n_edge == m_acc + m_lat - 1);
            check("busy", 64'(busy_o), 64'(m_pend));
            check("we", 64'(hilo_we_o), 64'(exp_we));
            if (exp_we) begin
               check("sb_depth", 64'(exp_q.size()), 64'd1);
               if (exp_q.size() != 0) begin
                  check("hilo", {hi_o, lo_o}, exp_q[0]);
                  void'(exp_q.pop_front());
               end
            end
            if (hilo_we_o) we_cnt++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hin, lin);
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; op_a_i = a; op_b_i = b; hi_i = hin; lo_i = lin;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'd0;
      op_a_i = ~a; op_b_i = ~b; hi_i = ~hin; lo_i = ~lin;
   endtask

   task automatic wait_wb(input string name, input int exp_lat, input logic [31:0] exp_hi, exp_lo);
      int j, nb;
      bit seen;
      j = 0; nb = 0; seen = 1'b0;
      while (!seen && j < 40) begin
         @(negedge clk);
         j++;
         if (busy_o) nb++;
         if (hilo_we_o) seen = 1'b1;
      end
      check({name, "_wb_seen"}, 64'(seen), 64'd1);
      check({name, "_lat"}, 64'(j), 64'(exp_lat));
      check({name, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
      check({name, "_hi"}, 64'(hi_o), 64'(exp_hi));
      check({name, "_lo"}, 64'(lo_o), 64'(exp_lo));
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, b, hin, lin,
                         input int exp_lat, input logic [31:0] exp_hi, exp_lo);
      issue(op, a, b, hin, lin);
      wait_wb(name, exp_lat, exp_hi, exp_lo);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wb0;
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0;
      op_a_i = '0; op_b_i = '0; hi_i = '0; lo_i = '0;
      #2 rst = 1'b0;
      #1;
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_we", 64'(hilo_we_o), 64'd0);
      check("reset_hi", 64'(hi_o), 64'd0);
      check("reset_lo", 64'(lo_o), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      run_op("mult_m2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        0, 0, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_m1xm1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, MUL_LAT, 32'h0, 32'h1);
      run_op("divu_100_7",  OP_DIVU,  32'd100, 32'd7,              0, 0, 34, 32'd2, 32'd14);
      run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2",    OP_DIV,   32'd7, 32'hFFFF_FFFE,        0, 0, 34, 32'd1, 32'hFFFF_FFFD);
      run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 34, 32'h0, 32'h8000_0000);
      run_op("divu_by0",    OP_DIVU,  32'd5, 32'd0,                0, 0, 1, 32'd5, 32'hFFFF_FFFF);
      run_op("div_by0",     OP_DIV,   32'hFFFF_FFF0, 32'd0,        0, 0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      run_op("mtlo",        OP_MTLO,  32'h1234, 32'h0, 32'hAAAA, 32'h5555, 1, 32'hAAAA, 32'h1234);

      // flush while idle must block acceptance
      @(posedge clk); #1;
      start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULT; op_a_i = 32'd9; op_b_i = 32'd9;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0;
      check("idle_flush_blocks", 64'(busy_o), 64'd0);

      // flush mid-divide at k+10, then a MULT accepted at k+11
      wb0 = we_cnt;
      issue(OP_DIV, 32'd1000, 32'd3, 0, 0);
      repeat (9) @(posedge clk);
      #1;
      check("flush_busy_k10", 64'(busy_o), 64'd1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_busy_k11", 64'(busy_o), 64'd0);
      start_i = 1'b1; op_i = OP_MULT; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'd5;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'd0;
      wait_wb("post_flush_mult", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      @(posedge clk); #1;
      check("flush_write_count", 64'(we_cnt - wb0), 64'd1);

      // start held through the whole operation: exactly one write
      wb0 = we_cnt;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = OP_DIVU; op_a_i = 32'd1000; op_b_i = 32'd10;
      @(posedge clk); #1;
      wait_wb("held_start", 34, 32'd0, 32'd100);
      start_i = 1'b0; op_i = 3'd0;
      repeat (40) @(posedge clk);
      #1;
      check("held_one_write", 64'(we_cnt - wb0), 64'd1);

      // flush during the write cycle does not cancel it
      issue(OP_MTHI, 32'h5A5A_5A5A, 32'h0, 32'h1111, 32'hC3C3_C3C3);
      flush_i = 1'b1;
      wait_wb("mthi_wb_flush", 1, 32'h5A5A_5A5A, 32'hC3C3_C3C3);
      flush_i = 1'b0;

      // asynchronous reset in the middle of cycle k+5 of a divide
      issue(OP_DIV, 32'd77, 32'd5, 0, 0);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_we", 64'(hilo_we_o), 64'd0);
      check("midrst_hi", 64'(hi_o), 64'd0);
      check("midrst_lo", 64'(lo_o), 64'd0);
      wb0 = we_cnt;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("midrst_no_write", 64'(we_cnt - wb0), 64'd0);

      run_op("post_rst_multu", OP_MULTU, 32'd6, 32'd7, 0, 0, MUL_LAT, 32'd0, 32'd42);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      n_checks++;
      n_err++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
